// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, FSM states and limits for the MEM-stage data memory
package mem_pkg;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam int MAX_READ_LATENCY = 4;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  // offset of the last byte touched by an access; reserved size behaves as a word
  function automatic logic [1:0] size_last(input logic [1:0] size);
    return size == MEM_BYTE ? 2'd0 : size == MEM_HALF ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: M-stage request/response bundle between pipeline and data memory
interface data_mem_ctrl_if;
  logic        Mem_Read_M;
  logic        Mem_Write_M;
  logic [1:0]  Mem_Size_M;
  logic        Mem_Unsigned_M;
  logic [31:0] ALU_Result_M;
  logic [31:0] Write_Data_M;
  logic [31:0] Read_Data_M;
  logic        Mem_Valid;
  logic        Mem_Busy;
  logic        Mem_Misalign;
  logic        Mem_Range_Err;
  modport master (
    output Mem_Read_M, Mem_Write_M, Mem_Size_M, Mem_Unsigned_M, ALU_Result_M, Write_Data_M,
    input  Read_Data_M, Mem_Valid, Mem_Busy, Mem_Misalign, Mem_Range_Err
  );
  modport slave (
    input  Mem_Read_M, Mem_Write_M, Mem_Size_M, Mem_Unsigned_M, ALU_Result_M, Write_Data_M,
    output Read_Data_M, Mem_Valid, Mem_Busy, Mem_Misalign, Mem_Range_Err
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian store lane steering and load byte extraction/extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_uns,
  input  logic [31:0] raw,
  output logic [31:0] load_data
);
  logic [15:0] hsel;
  logic [7:0]  bsel;
  // lane i is byte address base+i and sits in bits [31-8i -: 8]
  always_comb begin
    be = size == MEM_BYTE ? 4'b0001 << off : size == MEM_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane_data = size == MEM_BYTE ? {4{store_data[7:0]}} : size == MEM_HALF ? {2{store_data[15:0]}} : store_data;
    hsel = ld_off[1] ? raw[15:0] : raw[31:16];
    bsel = ld_off[0] ? hsel[7:0] : hsel[15:8];
    load_data = ld_size == MEM_BYTE ? {{24{bsel[7] & ~ld_uns}}, bsel} :
                ld_size == MEM_HALF ? {{16{hsel[15] & ~ld_uns}}, hsel} : raw;
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed big-endian data memory with configurable read latency and busy/valid stall
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input logic             clk,
  input logic             rst_n,
  data_mem_ctrl_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW = $clog2(MAX_READ_LATENCY);
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0] raw, lane_data, load_data;
  logic [1:0] ld_size, ld_off;
  logic ld_uns, req, fault, accept, store;
  logic [3:0] be;
  logic [32:0] last;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [7:0] mem [DEPTH];
  mem_lane_align u_align (
    .size(bus.Mem_Size_M), .off(bus.ALU_Result_M[1:0]), .store_data(bus.Write_Data_M),
    .be(be), .lane_data(lane_data),
    .ld_size(ld_size), .ld_off(ld_off), .ld_uns(ld_uns), .raw(raw), .load_data(load_data)
  );
  // rst_n gating keeps Busy low and blocks writes while reset is held
  always_comb begin
    req = bus.Mem_Read_M | bus.Mem_Write_M;
    word_idx = bus.ALU_Result_M[ADDR_WIDTH-1:2];
    last = {1'b0, bus.ALU_Result_M} + 33'(size_last(bus.Mem_Size_M));
    bus.Mem_Misalign = req & (bus.Mem_Size_M == MEM_HALF ? bus.ALU_Result_M[0] : bus.Mem_Size_M[1] & |bus.ALU_Result_M[1:0]);
    bus.Mem_Range_Err = req & (last >= 33'(DEPTH));
    fault = bus.Mem_Misalign | bus.Mem_Range_Err;
    store = rst_n & state == IDLE & bus.Mem_Write_M & ~fault;
    accept = rst_n & state == IDLE & bus.Mem_Read_M & ~bus.Mem_Write_M & ~fault;
    state_next = state;
    state_next = state == WAIT ? (cnt == CW'(1) ? DONE : WAIT) : accept ? (READ_LATENCY == 1 ? DONE : WAIT) : IDLE;
    bus.Mem_Busy = accept | state == WAIT;
    bus.Mem_Valid = state == DONE;
    bus.Read_Data_M = state == DONE ? load_data : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      raw <= '0;
      ld_size <= '0;
      ld_off <= '0;
      ld_uns <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= accept ? CW'(READ_LATENCY - 1) : state == WAIT ? cnt - 1'b1 : cnt;
      if (accept) begin
        raw <= {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}], mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};
        ld_size <= bus.Mem_Size_M;
        ld_off <= bus.ALU_Result_M[1:0];
        ld_uns <= bus.Mem_Unsigned_M;
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (store & be[i]) mem[{word_idx, 2'(i)}] <= lane_data[31-8*i -: 8];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench over four instances with read latency 1..4
module tb_data_mem_ctrl;
  import mem_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] rd;
  logic wr, uns;
  logic [1:0] size;
  logic [31:0] addr, wdata;
  logic [3:0] busy, valid, mis, rng;
  logic [31:0] rdata [4];
  logic [31:0] sb [$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  data_mem_ctrl_if bus0 ();
  data_mem_ctrl_if bus1 ();
  data_mem_ctrl_if bus2 ();
  data_mem_ctrl_if bus3 ();
  assign {bus0.Mem_Read_M, bus0.Mem_Write_M, bus0.Mem_Size_M, bus0.Mem_Unsigned_M, bus0.ALU_Result_M, bus0.Write_Data_M} = {rd[0], wr, size, uns, addr, wdata};
  assign {bus1.Mem_Read_M, bus1.Mem_Write_M, bus1.Mem_Size_M, bus1.Mem_Unsigned_M, bus1.ALU_Result_M, bus1.Write_Data_M} = {rd[1], wr, size, uns, addr, wdata};
  assign {bus2.Mem_Read_M, bus2.Mem_Write_M, bus2.Mem_Size_M, bus2.Mem_Unsigned_M, bus2.ALU_Result_M, bus2.Write_Data_M} = {rd[2], wr, size, uns, addr, wdata};
  assign {bus3.Mem_Read_M, bus3.Mem_Write_M, bus3.Mem_Size_M, bus3.Mem_Unsigned_M, bus3.ALU_Result_M, bus3.Write_Data_M} = {rd[3], wr, size, uns, addr, wdata};
  assign {busy[0], valid[0], mis[0], rng[0], rdata[0]} = {bus0.Mem_Busy, bus0.Mem_Valid, bus0.Mem_Misalign, bus0.Mem_Range_Err, bus0.Read_Data_M};
  assign {busy[1], valid[1], mis[1], rng[1], rdata[1]} = {bus1.Mem_Busy, bus1.Mem_Valid, bus1.Mem_Misalign, bus1.Mem_Range_Err, bus1.Read_Data_M};
  assign {busy[2], valid[2], mis[2], rng[2], rdata[2]} = {bus2.Mem_Busy, bus2.Mem_Valid, bus2.Mem_Misalign, bus2.Mem_Range_Err, bus2.Read_Data_M};
  assign {busy[3], valid[3], mis[3], rng[3], rdata[3]} = {bus3.Mem_Busy, bus3.Mem_Valid, bus3.Mem_Misalign, bus3.Mem_Range_Err, bus3.Read_Data_M};
  data_mem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  data_mem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  data_mem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  data_mem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  task automatic run_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, output logic m, output logic r, output logic b);
    @(negedge clk);
    addr = a; size = s; wdata = d; rd = '0; wr = 1'b1;
    #1 m = mis[0]; r = rng[0]; b = busy[0];
    @(negedge clk);
    wr = 1'b0;
  endtask

  // holds the read through DONE and drops it one cycle later, so any re-trigger shows up as extra busy/valid
  task automatic run_load(input int d, input logic [31:0] a, input logic [1:0] s, input logic u,
                          output logic [31:0] data, output int busy_cyc, output int valid_cnt, output logic m, output logic r);
    bit drop = 0;
    @(negedge clk);
    addr = a; size = s; uns = u; wr = 1'b0; rd[d] = 1'b1;
    data = '0; busy_cyc = 0; valid_cnt = 0; m = 1'b0; r = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k == 0) begin m = mis[d]; r = rng[d]; end
      busy_cyc += int'(busy[d]);
      if (valid[d]) begin valid_cnt++; data = rdata[d]; drop = 1; end
      @(negedge clk);
      if (drop) rd[d] = 1'b0;
    end
    rd[d] = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({busy[d], valid[d], rdata[d]} !== 34'h0) begin failures++; $display("FAIL reset_out[%0d]: got busy=%b valid=%b data=%h want 0/0/0", d, busy[d], valid[d], rdata[d]); end
    end
    addr = 32'h12; size = MEM_WORD; rd[0] = 1'b1;
    #1 checks++;
    if (mis[0] !== 1'b1 || busy[0] !== 1'b0) begin failures++; $display("FAIL reset_fault_follow: got mis=%b busy=%b want 1/0", mis[0], busy[0]); end
    rd[0] = 1'b0;
    #1 checks++;
    if (mis[0] !== 1'b0) begin failures++; $display("FAIL reset_no_req_mis: got %b want 0", mis[0]); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) #1 checks++;
    if ({busy[0], valid[0], rdata[0]} !== 34'h0) begin failures++; $display("FAIL post_reset_idle: got busy=%b valid=%b data=%h", busy[0], valid[0], rdata[0]); end
  endtask

  task automatic test_word;
    logic m, r, b; logic [31:0] got; int bc, vc;
    logic [7:0] bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_store(32'h10, MEM_WORD, 32'hDEADBEEF, m, r, b);
    checks++;
    if ({m, r, b} !== 3'b000) begin failures++; $display("FAIL sw_flags: got mis=%b rng=%b busy=%b want 000", m, r, b); end
    sb.push_back(32'hDEADBEEF);
    run_load(0, 32'h10, MEM_WORD, 1'b0, got, bc, vc, m, r);
    checks++;
    if (got !== sb.pop_front() || bc != 1 || vc != 1) begin failures++; $display("FAIL lw_0x10: got data=%h busy=%0d valid=%0d want deadbeef 1 1", got, bc, vc); end
    for (int i = 0; i < 4; i++) begin
      sb.push_back({24'h0, bytes[i]});
      run_load(0, 32'h10 + i, MEM_BYTE, 1'b1, got, bc, vc, m, r);
      checks++;
      if (got !== sb.pop_front()) begin failures++; $display("FAIL byte_order@%0h: got %h want %h", 32'h10 + i, got, {24'h0, bytes[i]}); end
    end
  endtask

  task automatic test_subword_loads;
    logic m, r; logic [31:0] got; int bc, vc;
    logic [31:0] a   [4] = '{32'h11, 32'h11, 32'h12, 32'h12};
    logic [1:0]  s   [4] = '{MEM_BYTE, MEM_BYTE, MEM_HALF, MEM_HALF};
    logic        u   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp [4] = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFBEEF, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(exp[i]);
      run_load(0, a[i], s[i], u[i], got, bc, vc, m, r);
      checks++;
      if (got !== sb.pop_front() || vc != 1) begin failures++; $display("FAIL subload[%0d]: got %h valid=%0d want %h", i, got, vc, exp[i]); end
    end
  endtask

  task automatic test_subword_stores;
    logic m, r, b; logic [31:0] got; int bc, vc;
    run_store(32'h13, MEM_BYTE, 32'h12345677, m, r, b);
    sb.push_back(32'hDEADBE77);
    run_load(0, 32'h10, MEM_WORD, 1'b0, got, bc, vc, m, r);
    checks++;
    if (got !== sb.pop_front()) begin failures++; $display("FAIL sb_then_lw: got %h want deadbe77", got); end
    run_store(32'h10, MEM_HALF, 32'hAAAA1234, m, r, b);
    sb.push_back(32'h1234BE77);
    run_load(0, 32'h10, MEM_WORD, 1'b0, got, bc, vc, m, r);
    checks++;
    if (got !== sb.pop_front()) begin failures++; $display("FAIL sh_then_lw: got %h want 1234be77", got); end
  endtask

  task automatic test_faults;
    logic m, r, b; logic [31:0] got; int bc, vc;
    run_load(0, 32'h12, MEM_WORD, 1'b0, got, bc, vc, m, r);
    checks++;
    if (m !== 1'b1 || bc != 0 || vc != 0) begin failures++; $display("FAIL lw_misalign: got mis=%b busy=%0d valid=%0d want 1 0 0", m, bc, vc); end
    run_store(32'h3FC, MEM_WORD, 32'h01020304, m, r, b);
    run_store(32'h3FE, MEM_WORD, 32'hFFFFFFFF, m, r, b);
    checks++;
    if (r !== 1'b1 || b !== 1'b0) begin failures++; $display("FAIL sw_range: got rng=%b busy=%b want 1 0", r, b); end
    sb.push_back(32'h01020304);
    run_load(0, 32'h3FC, MEM_WORD, 1'b0, got, bc, vc, m, r);
    checks++;
    if (got !== sb.pop_front()) begin failures++; $display("FAIL range_unchanged: got %h want 01020304", got); end
    run_store(32'h0, MEM_WORD, 32'h55667788, m, r, b);
    run_store(32'h400, MEM_BYTE, 32'h000000AA, m, r, b);
    checks++;
    if ({m, r} !== 2'b01) begin failures++; $display("FAIL sb_0x400_flags: got mis=%b rng=%b want 0 1", m, r); end
    sb.push_back(32'h55667788);
    run_load(0, 32'h0, MEM_WORD, 1'b0, got, bc, vc, m, r);
    checks++;
    if (got !== sb.pop_front()) begin failures++; $display("FAIL no_alias_0x400: got %h want 55667788", got); end
  endtask

  task automatic test_back_to_back;
    logic m, r; logic [31:0] got; int bc, vc;
    @(negedge clk) addr = 32'h20; size = MEM_WORD; wdata = 32'hCAFEF00D; rd = '0; wr = 1'b1;
    @(negedge clk) wr = 1'b0; rd[0] = 1'b1; sb.push_back(32'hCAFEF00D);
    #1 checks++;
    if (busy[0] !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", busy[0]); end
    @(negedge clk) #1 checks++;
    if (valid[0] !== 1'b1 || rdata[0] !== sb.pop_front()) begin failures++; $display("FAIL b2b_data: got valid=%b data=%h want 1 cafef00d", valid[0], rdata[0]); end
    rd[0] = 1'b0;
    @(negedge clk) addr = 32'h24; wdata = 32'h0BADCAFE; wr = 1'b1; rd[0] = 1'b1;
    #1 checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL rw_busy: got %b want 0", busy[0]); end
    @(negedge clk) wr = 1'b0; rd[0] = 1'b0;
    #1 checks++;
    if (valid[0] !== 1'b0) begin failures++; $display("FAIL rw_no_valid: got %b want 0", valid[0]); end
    sb.push_back(32'h0BADCAFE);
    run_load(0, 32'h24, MEM_WORD, 1'b0, got, bc, vc, m, r);
    checks++;
    if (got !== sb.pop_front()) begin failures++; $display("FAIL rw_store_won: got %h want 0badcafe", got); end
  endtask

  task automatic test_latency_sweep;
    logic m, r; logic [31:0] got; int bc, vc;
    for (int d = 0; d < 4; d++) begin
      sb.push_back(32'hFFFFBE77);
      run_load(d, 32'h12, MEM_HALF, 1'b0, got, bc, vc, m, r);
      checks++;
      if (got !== sb.pop_front() || bc != d + 1 || vc != 1) begin failures++; $display("FAIL latency_L%0d: got data=%h busy=%0d valid=%0d want ffffbe77 %0d 1", d + 1, got, bc, vc, d + 1); end
    end
  endtask

  task automatic test_reset_mid_load;
    logic m, r; logic [31:0] got; int bc, vc, seen = 0;
    @(negedge clk) addr = 32'h10; size = MEM_WORD; uns = 1'b0; wr = 1'b0; rd[3] = 1'b1;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 checks++;
    if ({busy[3], valid[3], rdata[3]} !== 34'h0) begin failures++; $display("FAIL reset_mid_out: got busy=%b valid=%b data=%h want 0", busy[3], valid[3], rdata[3]); end
    rd[3] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); #1 seen += int'(valid[3]); end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL reset_no_valid: got %0d pulses want 0", seen); end
    sb.push_back(32'h1234BE77);
    run_load(3, 32'h10, MEM_WORD, 1'b0, got, bc, vc, m, r);
    checks++;
    if (got !== sb.pop_front() || bc != 4 || vc != 1) begin failures++; $display("FAIL reset_then_load: got data=%h busy=%0d valid=%0d want 1234be77 4 1", got, bc, vc); end
  endtask

  initial begin
    rst_n = 1'b0; rd = '0; wr = 1'b0; uns = 1'b0; size = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_word;
    test_subword_loads;
    test_subword_stores;
    test_faults;
    test_back_to_back;
    test_latency_sweep;
    test_reset_mid_load;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, multi-cycle successor to the MEM-stage data memory of the MIPS pipeline. Byte-addressed big-endian storage with byte/halfword/word loads and stores, sign or zero extension, alignment and range checking, and a configurable read latency that stalls the pipeline through a busy/valid handshake. Sits in the MEM stage between the EX/MEM and MEM/WB registers; the hazard unit consumes `Mem_Busy`.

## Interface
- `ADDR_WIDTH`, 10: byte-address bits used; depth = 2**ADDR_WIDTH bytes.
- `READ_LATENCY`, 1: cycles from load acceptance to data valid; legal range 1..4.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `Mem_Read_M` in 1: load request.
- `Mem_Write_M` in 1: store request.
- `Mem_Size_M` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- `Mem_Unsigned_M` in 1: zero-extend loads (lbu/lhu) when 1, else sign-extend.
- `ALU_Result_M` in 32: byte address.
- `Write_Data_M` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `Read_Data_M` out 32: extended load data; 0 whenever `Mem_Valid` is 0.
- `Mem_Valid` out 1: one-cycle pulse, load data present.
- `Mem_Busy` out 1: stall request to hazard unit.
- `Mem_Misalign` out 1: combinational, access misaligned for its size.
- `Mem_Range_Err` out 1: combinational, any addressed byte ≥ 2**ADDR_WIDTH.

## Operation
- States: IDLE, WAIT, DONE.
- Fault = `Mem_Misalign` | `Mem_Range_Err`, evaluated only when a request is present. Misaligned: half with addr[0]=1; word with addr[1:0]≠0. A faulting access writes nothing, launches no load, and keeps Busy low.
- Store (IDLE, `Mem_Write_M`, no fault): bytes written at the rising edge; single cycle, Busy stays 0. Big-endian: the word's MSB goes to addr, LSB to addr+3; a halfword's [15:8] to addr, [7:0] to addr+1; a byte goes to addr.
- Load (IDLE, `Mem_Read_M`, no fault, no write): accepted. The raw bytes are captured at the acceptance edge. The FSM goes to WAIT with counter = READ_LATENCY-1, or to DONE if READ_LATENCY=1.
- WAIT: counter decrements each cycle; moves to DONE when the counter reaches 0.
- DONE: `Mem_Valid`=1 and `Read_Data_M` is driven. The FSM returns to IDLE unconditionally at the next edge, so the held `Mem_Read_M` does not re-trigger.
- Extension: byte/half are sign- or zero-extended per `Mem_Unsigned_M`; word is passed through.
- `Mem_Read_M` and `Mem_Write_M` both high: store performed, load ignored.
- Requests in WAIT/DONE are ignored; the stalled pipeline holds the M-stage inputs stable.
- Memory contents are not reset.

## Timing
- Reset: state IDLE, counter 0, capture register 0. `Read_Data_M`=0, `Mem_Valid`=0, `Mem_Busy`=0. Fault outputs follow their inputs.
- Reset mid-load aborts the load: no `Mem_Valid` pulse, and memory is unchanged.
- Acceptance cycle is c0. `Mem_Busy`=1 in cycles c0..c(L-1), combinational in c0 from IDLE & read & !fault. `Mem_Valid`=1 and `Busy`=0 in cycle cL. Total stall = L cycles.
- Store followed by a load of the same address in the next cycle returns the new data.

## Structure
- Shared package `mem_pkg`: size encodings (`MEM_BYTE`, `MEM_HALF`, `MEM_WORD`), FSM state enum, `MAX_READ_LATENCY`=4.
- Sub-module `mem_lane_align`: combinational. Produces the store byte-enables and lane data from size and addr[1:0], and performs load byte extraction and extension.

## Test plan
- Word store/load: sw 0xDEADBEEF @0x10, then lw @0x10 with L=1. Busy high for 1 cycle, then Valid with 0xDEADBEEF. Bytes 0x10..0x13 = DE AD BE EF.
- Sub-word loads: lb @0x11 → 0xFFFFFFAD; lbu @0x11 → 0x000000AD; lh @0x12 → 0xFFFFBEEF; lhu @0x12 → 0x0000BEEF.
- Sub-word stores: sb 0x12345677 @0x13 then lw @0x10 → 0xDEADBE77. sh 0xAAAA1234 @0x10 then lw → 0x1234BE77.
- Faults: lw @0x12 → Misalign=1, Busy=0, Valid never pulses. sw @0x3FE → Range_Err=1 and memory unchanged.
- Latency sweep: L=1..4. Busy held exactly L cycles, a single Valid pulse, and no re-trigger while `Mem_Read_M` stays high through DONE.
- Reset during WAIT (L=4, `rst_n` low in c2): outputs go to 0 immediately, there is no Valid pulse, and a following load behaves normally.
